// File: rtl/sipo_pkg.sv
// Shared constants for the serial-in / parallel-out deserializer.
// Holds the default word width and the FSM state encoding used by sipo_deser.
// Optional feature macro honoured by the design: SIPO_DESER_PARITY_EN.
package sipo_pkg;

  // Default deserialized word width in bits.
  localparam int unsigned SIPO_WIDTH = 16;

  // FSM state encoding, kept as plain constants for legacy compatibility.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] PAR   = 2'd2;

endpackage : sipo_pkg

// File: rtl/sipo_bitcnt.sv
// Frame bit counter for sipo_deser.
// Ports:
//   CLK   - clock, rising edge
//   RST   - asynchronous active-low reset
//   clr   - synchronous clear (frame start / abort)
//   inc   - count one sampled bit
//   tc_c  - combinational terminal count: the next sampled bit is the last data bit
module sipo_bitcnt
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_WIDTH
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output logic tc_c
);

  // Wide enough to hold WIDTH itself, so a full frame never wraps.
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt;

  // Counter register; saturates at WIDTH as a guard against wrap.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CW'(WIDTH))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc_c = (cnt == CW'(WIDTH - 1));

endmodule : sipo_bitcnt

// File: rtl/sipo_deser.sv
// Serial-in / parallel-out deserializer with valid/acknowledge output handshake.
// Assembles WIDTH bits (MSB first, qualified by SEN) after a START strobe and
// presents the word on DOUT with DVALID until acknowledged.
// Optional feature macro: SIPO_DESER_PARITY_EN adds an even-parity bit after
// the data bits (PAR state) and drives PERR; without it PERR is constant 0.
// Ports:
//   CLK    - clock, rising edge
//   RST    - asynchronous active-low reset
//   START  - frame-start strobe (aborts a frame in progress)
//   SEN    - serial-bit-valid qualifier
//   SIN    - serial data, MSB first
//   DACK   - consumer acknowledge of DOUT
//   DOUT   - assembled word (registered)
//   DVALID - DOUT holds an unacknowledged word
//   BUSY   - frame in progress (SHIFT or PAR)
//   OVF    - sticky: a completed word was dropped
//   FERR   - one-cycle pulse: partial frame aborted by START
//   PERR   - parity error accompanying DVALID
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SEN,
  input  logic             SIN,
  input  logic             DACK,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  output logic             BUSY,
  output logic             OVF,
  output logic             FERR,
  output logic             PERR
);

  // With parity the whole word must be held while waiting for the parity bit;
  // without it the last data bit goes straight from SIN into DOUT.
`ifdef SIPO_DESER_PARITY_EN
  localparam int unsigned SHW = WIDTH;
`else
  localparam int unsigned SHW = WIDTH - 1;
`endif

  logic [1:0]     state;
  logic [1:0]     state_nxt;
  logic [SHW-1:0] shreg;
  logic [WIDTH-1:0] word_c;
  logic           tc_c;
  logic           cnt_clr;
  logic           cnt_inc;
  logic           shift_en;
  logic           deliver;
  logic           ferr_nxt;

`ifdef SIPO_DESER_PARITY_EN
  logic           par_c;

  // Word already complete in shreg; error if data plus parity bit is odd.
  assign word_c = shreg;
  assign par_c  = (^shreg) ^ SIN;
`else
  assign word_c = {shreg, SIN};
`endif

  sipo_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .tc_c (tc_c)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control; START always wins over a completing bit.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    shift_en  = 1'b0;
    deliver   = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          state_nxt = SHIFT;
          cnt_clr   = 1'b1;
        end
      end
      SHIFT: begin
        if (START) begin
          ferr_nxt = 1'b1;
          cnt_clr  = 1'b1;
        end else if (SEN) begin
          shift_en = 1'b1;
          cnt_inc  = 1'b1;
          if (tc_c) begin
`ifdef SIPO_DESER_PARITY_EN
            state_nxt = PAR;
`else
            deliver   = 1'b1;
            state_nxt = IDLE;
`endif
          end
        end
      end
`ifdef SIPO_DESER_PARITY_EN
      PAR: begin
        if (START) begin
          ferr_nxt  = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = SHIFT;
        end else if (SEN) begin
          deliver   = 1'b1;
          state_nxt = IDLE;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shift register and status flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg <= '0;
      BUSY  <= 1'b0;
      FERR  <= 1'b0;
    end else begin
      BUSY <= (state_nxt != IDLE);
      FERR <= ferr_nxt;
      if (cnt_clr) begin
        shreg <= '0;
      end else if (shift_en) begin
        shreg <= SHW'({shreg, SIN});
      end
    end
  end

  // Output word handshake: load when free or being acknowledged, else drop and flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DOUT   <= '0;
      DVALID <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      if (deliver && (!DVALID || DACK)) begin
        DOUT   <= word_c;
        DVALID <= 1'b1;
      end else begin
        if (deliver) begin
          OVF <= 1'b1;
        end
        if (DACK) begin
          DVALID <= 1'b0;
        end
      end
    end
  end

`ifdef SIPO_DESER_PARITY_EN
  // Parity flag travels with the word it describes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PERR <= 1'b0;
    end else if (deliver && (!DVALID || DACK)) begin
      PERR <= par_c;
    end else if (DACK && !deliver) begin
      PERR <= 1'b0;
    end
  end
`else
  assign PERR = 1'b0;
`endif

endmodule : sipo_deser

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser (WIDTH=16).
// Honours SIPO_DESER_PARITY_EN the same way as the design.
module tb_sipo_deser;

  localparam int unsigned W = 16;
`ifdef SIPO_DESER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic         CLK   = 1'b0;
  logic         RST   = 1'b0;
  logic         START = 1'b0;
  logic         SEN   = 1'b0;
  logic         SIN   = 1'b0;
  logic         DACK  = 1'b0;
  logic [W-1:0] DOUT;
  logic         DVALID;
  logic         BUSY;
  logic         OVF;
  logic         FERR;
  logic         PERR;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;
  int ferr_cnt = 0;
  int e0;
  int f0;

  always #5 CLK = ~CLK;

  sipo_deser #(
    .WIDTH (W)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .SEN    (SEN),
    .SIN    (SIN),
    .DACK   (DACK),
    .DOUT   (DOUT),
    .DVALID (DVALID),
    .BUSY   (BUSY),
    .OVF    (OVF),
    .FERR   (FERR),
    .PERR   (PERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"},   32'(DOUT),   32'h0);
    chk({tag, "_dvalid"}, 32'(DVALID), 32'h0);
    chk({tag, "_ovf"},    32'(OVF),    32'h0);
    chk({tag, "_ferr"},   32'(FERR),   32'h0);
    chk({tag, "_perr"},   32'(PERR),   32'h0);
    chk({tag, "_busy"},   32'(BUSY),   32'h0);
  endtask

  // One clock: drive inputs, take the edge, settle, tally FERR pulses.
  task automatic cyc(input logic st, input logic sen, input logic sin, input logic ack);
    START = st;
    SEN   = sen;
    SIN   = sin;
    DACK  = ack;
    @(posedge CLK);
    #1;
    edges++;
    ferr_cnt += int'(FERR);
  endtask

  // Send the top nbits of w MSB first; optional one-cycle SEN gaps after
  // bit numbers gap_a/gap_b; a full word gets its parity bit when enabled.
  task automatic send_bits(input logic [W-1:0] w, input int nbits, input int gap_a,
                           input int gap_b, input logic ack_last, input logic par_flip);
    for (int k = 0; k < nbits; k++) begin
      cyc(1'b0, 1'b1, w[W-1-k], ((k == nbits - 1) && !(PB == 1 && nbits == W)) ? ack_last : 1'b0);
      if ((k + 1 == gap_a) || (k + 1 == gap_b)) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (PB == 1 && nbits == W) cyc(1'b0, 1'b1, (^w) ^ par_flip, ack_last);
  endtask

  task automatic frame(input logic [W-1:0] w, input int gap_a, input int gap_b,
                       input logic ack_last, input logic par_flip);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(w, int'(W), gap_a, gap_b, ack_last, par_flip);
  endtask

  task automatic pulse_rst(input string tag);
    RST = 1'b0;
    #1;
    chk_zero(tag);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk_zero("reset");
    RST = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // SEN/SIN ignored in IDLE
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("idle_busy", 32'(BUSY), 32'h0);
    chk("idle_dvalid", 32'(DVALID), 32'h0);

    // Basic frame A5C3, DVALID right after the last sampled bit
    e0 = edges;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("start_busy", 32'(BUSY), 32'h1);
    send_bits(16'hA5C3, int'(W) - 1, 0, 0, 1'b0, 1'b0);
    chk("a5_pre_dvalid", 32'(DVALID), 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
`ifdef SIPO_DESER_PARITY_EN
    chk("a5_par_busy", 32'(BUSY), 32'h1);
    chk("a5_par_dvalid", 32'(DVALID), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
`endif
    chk("a5_lat", 32'(edges - e0), 32'(1 + W + PB));
    chk("a5_dvalid", 32'(DVALID), 32'h1);
    chk("a5_dout", 32'(DOUT), 32'h0000A5C3);
    chk("a5_ferr", 32'(FERR), 32'h0);
    chk("a5_ovf", 32'(OVF), 32'h0);
    chk("a5_busy", 32'(BUSY), 32'h0);
    chk("a5_perr", 32'(PERR), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("a5_hold", 32'(DVALID), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("a5_ack", 32'(DVALID), 32'h0);
    chk("a5_ack_dout", 32'(DOUT), 32'h0000A5C3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("stray_ack", 32'(DVALID), 32'h0);

    // SEN gaps after bits 3 and 9 add exactly two cycles
    e0 = edges;
    frame(16'hA5C3, 3, 9, 1'b0, 1'b0);
    chk("gap_lat", 32'(edges - e0), 32'(1 + W + 2 + PB));
    chk("gap_dvalid", 32'(DVALID), 32'h1);
    chk("gap_dout", 32'(DOUT), 32'h0000A5C3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Overflow: second word dropped when unacknowledged
    frame(16'h1234, 0, 0, 1'b0, 1'b0);
    chk("ovf1_dout", 32'(DOUT), 32'h00001234);
    chk("ovf1_ovf", 32'(OVF), 32'h0);
    frame(16'hBEEF, 0, 0, 1'b0, 1'b0);
    chk("ovf2_dout", 32'(DOUT), 32'h00001234);
    chk("ovf2_ovf", 32'(OVF), 32'h1);
    chk("ovf2_dvalid", 32'(DVALID), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_sticky", 32'(OVF), 32'h1);
    pulse_rst("ovf_rst");

    // Acknowledge on the completion cycle replaces the word
    frame(16'h1234, 0, 0, 1'b0, 1'b0);
    frame(16'hBEEF, 0, 0, 1'b1, 1'b0);
    chk("ackc_dout", 32'(DOUT), 32'h0000BEEF);
    chk("ackc_dvalid", 32'(DVALID), 32'h1);
    chk("ackc_ovf", 32'(OVF), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // START mid-frame (on bit 7) aborts, then a full 00FF
    f0 = ferr_cnt;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(16'hFFFF, 6, 0, 0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("abort_ferr", 32'(FERR), 32'h1);
    chk("abort_busy", 32'(BUSY), 32'h1);
    send_bits(16'h00FF, int'(W), 0, 0, 1'b0, 1'b0);
    chk("abort_ferr_cnt", 32'(ferr_cnt - f0), 32'h1);
    chk("abort_dout", 32'(DOUT), 32'h000000FF);
    chk("abort_dvalid", 32'(DVALID), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // START on the completing cycle wins: word discarded
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(16'hFFFF, int'(W) - 1, 0, 0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("prio_ferr", 32'(FERR), 32'h1);
    chk("prio_dvalid", 32'(DVALID), 32'h0);
    chk("prio_dout", 32'(DOUT), 32'h000000FF);
    send_bits(16'h5A5A, int'(W), 0, 0, 1'b0, 1'b0);
    chk("prio_next_dout", 32'(DOUT), 32'h00005A5A);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset at bit 10, then a full FFFF with no FERR
    f0 = ferr_cnt;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(16'h1234, 10, 0, 0, 1'b0, 1'b0);
    pulse_rst("midrst");
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("midrst_idle", 32'(BUSY), 32'h0);
    frame(16'hFFFF, 0, 0, 1'b0, 1'b0);
    chk("midrst_dout", 32'(DOUT), 32'h0000FFFF);
    chk("midrst_dvalid", 32'(DVALID), 32'h1);
    chk("midrst_ferr", 32'(ferr_cnt - f0), 32'h0);
    chk("midrst_perr", 32'(PERR), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_DESER_PARITY_EN
    // Even parity: correct bit clears PERR, wrong bit sets it
    frame(16'h0001, 0, 0, 1'b0, 1'b0);
    chk("par1_dout", 32'(DOUT), 32'h00000001);
    chk("par1_perr", 32'(PERR), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    frame(16'h0003, 0, 0, 1'b0, 1'b1);
    chk("par3_dout", 32'(DOUT), 32'h00000003);
    chk("par3_perr", 32'(PERR), 32'h1);
    chk("par3_dvalid", 32'(DVALID), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
`else
    frame(16'h0003, 0, 0, 1'b0, 1'b0);
    chk("nopar_dout", 32'(DOUT), 32'h00000003);
    chk("nopar_perr", 32'(PERR), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sipo_deser

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the deserialized word width in bits (legal 2..32).
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port START  input  1  frame-start strobe, aligned with the upstream serializer's load cycle.
REQ-005 SHALL have port SEN  input  1  serial-bit-valid qualifier; SIN is sampled only when SEN=1.
REQ-006 SHALL have port SIN  input  1  serial data, MSB first.
REQ-007 SHALL have port DACK  input  1  consumer acknowledge of DOUT.
REQ-008 SHALL have port DOUT  output  WIDTH  assembled word (registered).
REQ-009 SHALL have port DVALID  output  1  DOUT holds an unacknowledged word.
REQ-010 SHALL have port BUSY  output  1  high while in SHIFT or PAR.
REQ-011 SHALL have port OVF  output  1  sticky overflow: a completed word was dropped.
REQ-012 SHALL have port FERR  output  1  one-cycle pulse: a partial frame was aborted.
REQ-013 SHALL have port PERR  output  1  parity error flag accompanying DVALID.

Function
REQ-014 SHALL implement states IDLE, SHIFT and PAR (PAR only when the parity feature is compiled in).
REQ-015 In IDLE, START=1 SHALL move to SHIFT and clear the bit counter; SEN/SIN are ignored in IDLE and on the START cycle.
REQ-016 In SHIFT, each cycle with SEN=1 SHALL shift SIN into the shift-register LSB and increment the counter; SEN=0 cycles hold all state.
REQ-017 The WIDTH-th sampled bit SHALL complete the word {shreg[WIDTH-2:0],SIN}; the word then goes to PAR if parity is enabled, else is delivered and the FSM returns to IDLE.
REQ-018 Delivery SHALL load DOUT and set DVALID on the edge that samples the last bit (or the parity bit), giving DVALID one cycle after the last SIN sample.
REQ-019 DVALID SHALL remain high until a cycle with DACK=1; DACK while DVALID=0 SHALL have no effect.
REQ-020 Delivery with DVALID=1 and DACK=1 in the same cycle SHALL load the new word and keep DVALID=1.
REQ-021 Delivery with DVALID=1 and DACK=0 SHALL drop the new word, keep DOUT unchanged, and set OVF (cleared only by reset).
REQ-022 START=1 in SHIFT or PAR SHALL discard the partial word, pulse FERR for one cycle, clear the counter and restart in SHIFT.
REQ-023 START=1 on the same cycle that would complete a word SHALL take priority: the word is discarded and FERR pulses.
REQ-024 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap within a frame.

Reset
REQ-025 RST=0 SHALL asynchronously force IDLE, counter=0, shreg=0, DOUT=0, DVALID=0, OVF=0, FERR=0, PERR=0, BUSY=0.
REQ-026 Reset mid-frame SHALL discard the partial word with no FERR pulse; operation resumes on the first START after RST=1.

Configuration
REQ-027 Macro SIPO_DESER_PARITY_EN defined: one extra SEN-qualified bit after the WIDTH data bits SHALL be sampled in PAR as even parity, and PERR SHALL be loaded with (XOR of data bits XOR parity bit) together with DOUT.
REQ-028 Macro SIPO_DESER_PARITY_EN undefined: the PAR state SHALL be absent and PERR SHALL be constant 0.

Structure
REQ-029 Shared package sipo_pkg SHALL hold the state encoding (IDLE=2'd0, SHIFT=2'd1, PAR=2'd2) and the default width constant SIPO_WIDTH=16.
REQ-030 Bit counting SHALL live in sub-module sipo_bitcnt (clear, increment, terminal-count output); all other logic stays in sipo_deser.

Verification
REQ-031 START, then 16 SEN=1 bits of 16'hA5C3 MSB first -> DVALID=1 the cycle after bit 16, DOUT=16'hA5C3, FERR=0, OVF=0.
REQ-032 Same word with SEN=0 gaps after bits 3 and 9 -> DOUT=16'hA5C3, DVALID delayed by exactly 2 cycles.
REQ-033 Two back-to-back frames 16'h1234 and 16'hBEEF, DACK held 0 -> DOUT stays 16'h1234, OVF=1; repeat with DACK=1 on the 2nd completion cycle -> DOUT=16'hBEEF, OVF=0.
REQ-034 START at bit 7 of a frame, then a full 16'h00FF -> FERR pulses once, DOUT=16'h00FF.
REQ-035 RST=0 for one cycle at bit 10, then a full frame 16'hFFFF -> all outputs 0 during reset, DOUT=16'hFFFF, FERR never pulses.
REQ-036 With SIPO_DESER_PARITY_EN: 16'h0001 with parity bit 1 -> PERR=0; 16'h0003 with parity bit 1 -> PERR=1, DOUT=16'h0003.
